cpa_chunk_sequencer: RTL and testbench

Multi-cycle wide adder/subtractor controller. It accepts one WIDTH-bit operation through a valid/ready handshake and drives a single CHUNK-bit lookahead carry-propagate adder over NUM_CHUNKS = WIDTH/CHUNK consecutive cycles, least-significant chunk first. Between cycles it registers the inter-chunk carry. It sits between the modular-arithmetic pipeline and the shared CPA datapath, so wide additions do not need a full-width combinational adder.

---
 rtl/cpa_chunk_sequencer.sv | 147 ++++++++++++++
 tb/tb_cpa_chunk_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpa_chunk_sequencer.sv
// Multi-cycle wide add/subtract: one WIDTH-bit operation is summed CHUNK bits per
// cycle through a 4-bit-group lookahead adder, least-significant chunk first.
module cpa_chunk_sequencer #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned NUM_GROUPS = CHUNK / 4;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  generate
    if (((WIDTH % CHUNK) != 0) || ((CHUNK % 4) != 0)) begin : g_bad_params
      $error("cpa_chunk_sequencer: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
  logic               carry, cout_reg;
  logic [IDX_W-1:0]   idx;
  logic               last_chunk;

  logic [CHUNK-1:0]      bit_g, bit_p, chunk_sum;
  logic [NUM_GROUPS-1:0] grp_g, grp_p;
  logic [NUM_GROUPS:0]   grp_c;
  logic                  chunk_cout;
  logic                  la_acc, la_prop, bit_carry;

  // Chunk adder: per-group generate/propagate, then every group carry is expanded
  // directly from carry-in (no ripple between groups); bits ripple inside a group.
  always_comb begin
    bit_g     = a_reg[CHUNK-1:0] & b_reg[CHUNK-1:0];
    bit_p     = a_reg[CHUNK-1:0] ^ b_reg[CHUNK-1:0];
    grp_g     = '0;
    grp_p     = '0;
    grp_c     = '0;
    chunk_sum = '0;
    la_acc    = 1'b0;
    la_prop   = 1'b0;
    bit_carry = 1'b0;
    for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
      grp_p[k] = &bit_p[4*k +: 4];
      grp_g[k] = bit_g[4*k+3]
               | (bit_p[4*k+3] & bit_g[4*k+2])
               | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
               | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
    end
    grp_c[0] = carry;
    for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
      la_acc  = grp_g[k];
      la_prop = grp_p[k];
      for (int unsigned j = k; j > 0; j--) begin
        la_acc  = la_acc | (la_prop & grp_g[j-1]);
        la_prop = la_prop & grp_p[j-1];
      end
      grp_c[k+1] = la_acc | (la_prop & carry);
    end
    for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
      bit_carry = grp_c[k];
      for (int unsigned i = 0; i < 4; i++) begin
        chunk_sum[4*k+i] = bit_p[4*k+i] ^ bit_carry;
        bit_carry        = bit_g[4*k+i] | (bit_p[4*k+i] & bit_carry);
      end
    end
    chunk_cout = grp_c[NUM_GROUPS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      idx      <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_reg <= in_a;
        b_reg <= in_sub ? ~in_b : in_b;
        carry <= in_sub | in_cin;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      // Completed chunks enter at the top so the result is aligned after the last one.
      sum_reg <= (sum_reg >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
      a_reg   <= a_reg >> CHUNK;
      b_reg   <= b_reg >> CHUNK;
      carry   <= chunk_cout;
      idx     <= idx + IDX_W'(1);
      if (last_chunk) cout_reg <= chunk_cout;
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;

endmodule

// File: tb/tb_cpa_chunk_sequencer.sv
// Scoreboard bench for cpa_chunk_sequencer: the driver queues expected results on
// accept, a negedge monitor pops and compares on every output handshake.
module tb_cpa_chunk_sequencer;

  localparam int unsigned WIDTH = 256;
  localparam int unsigned CHUNK = 64;

  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, in_cin, in_sub;
  logic             out_valid, out_ready, out_cout, busy;
  logic [WIDTH-1:0] in_a, in_b, out_sum;
  logic             dir_ready, rnd_ready, rand_mode;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   n_pushed = 0;
  res_t exp_q[$];

  assign out_ready = rand_mode ? rnd_ready : dir_ready;

  always #5 clk = ~clk;

  cpa_chunk_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cout/sum %h required %h", name, act, exp);
    end
  endtask

  initial begin
    rnd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got sum %h with nothing queued, required no output", out_sum);
      end else begin
        chk_w("result", {out_cout, out_sum}, exp_q.pop_front());
      end
      n_out++;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input res_t e);
    int   guard;
    logic acc;
    guard    = 0;
    acc      = 1'b0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    while (!acc && guard < 200) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk_i("accept_timeout", guard, 0);
    else begin
      exp_q.push_back(e);
      n_pushed++;
    end
    in_valid = 1'b0;
    // Operand changes while running must not disturb the result.
    in_a   = {8{$urandom}};
    in_b   = {8{$urandom}};
    in_cin = 1'($urandom);
    in_sub = 1'($urandom);
  endtask

  task automatic wait_drain;
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 300) chk_i("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;
    logic [WIDTH:0]   model;
    int               n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    dir_ready = 1'b0;
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk_w("reset_result", {out_cout, out_sum}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ripple through every chunk, plus latency and single-cycle valid.
    dir_ready = 1'b1;
    send('1, '0, 1'b1, 1'b0, '{cout: 1'b1, sum: '0});
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    // Accept edge is cycle T; result visible during cycle T+5.
    chk_i("latency", n + 1, 5);
    @(posedge clk);
    #1;
    chk1("valid_one_cycle", out_valid, 1'b0);
    chk1("ready_after_done", in_ready, 1'b1);
    wait_drain();

    send({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 1'b0, 1'b0,
         '{cout: 1'b0, sum: {191'd0, 1'b1, 64'd0}});
    send(256'd5, 256'd7, 1'b1, 1'b1, '{cout: 1'b0, sum: ~256'd1});
    send(256'd7, 256'd5, 1'b0, 1'b1, '{cout: 1'b1, sum: 256'd2});
    send(256'h1234_5678, 256'h1234_5678, 1'b0, 1'b1, '{cout: 1'b1, sum: '0});
    wait_drain();

    // Backpressure with a second request pending the whole time.
    dir_ready = 1'b0;
    send(256'd100, 256'd23, 1'b0, 1'b0, '{cout: 1'b0, sum: 256'd123});
    in_a     = '1;
    in_b     = '1;
    in_cin   = 1'b1;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk_w("bp_hold", {out_cout, out_sum}, {1'b0, 256'd123});
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    dir_ready = 1'b1;
    @(posedge clk);
    #1;
    chk1("bp_ready_after_hs", in_ready, 1'b1);
    chk1("bp_valid_after_hs", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("bp_second_accepted", busy, 1'b1);
    exp_q.push_back('{cout: 1'b1, sum: '1});
    n_pushed++;
    in_valid = 1'b0;
    wait_drain();

    // Reset two cycles into a run discards the operation.
    send(256'd1, 256'd2, 1'b0, 1'b0, '{cout: 1'b0, sum: 256'd3});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk_w("rst_result", {out_cout, out_sum}, '0);
    n_pushed = n_pushed - exp_q.size();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk_i("no_output_after_reset", n, 0);

    // Back-to-back random operations with random consumer stalls.
    rand_mode = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      for (int w = 0; w < 8; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      if (k % 7 == 0) rb = ra;
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (rs) model = {1'b0, ra} + {1'b0, ~rb} + (WIDTH+1)'(1);
      else    model = {1'b0, ra} + {1'b0, rb} + (WIDTH+1)'(rc);
      send(ra, rb, rc, rs, model);
    end
    wait_drain();
    rand_mode = 1'b0;
    chk_i("output_count", n_out, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
